// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter that shares one single-outstanding memory
//                bus between an instruction-fetch port (IF) and a load/store
//                port (MEM). MEM normally has priority. A streak counter
//                guarantees that a waiting fetch wins after FAIR_LIMIT
//                consecutive MEM grants. Misaligned load/store requests are
//                answered with an error and never reach the bus.
//
//  Ports       : clk, rst                    - clock, synchronous active-high reset
//                if_req/if_addr              - fetch request (word read)
//                if_ready/if_rdata           - fetch completion and data
//                mem_req/we/size/addr/wdata  - load/store request
//                mem_ready/rdata/err         - load/store completion, data, error
//                bus_req/we/size/addr/wdata  - registered bus transaction controls
//                bus_ack/bus_rdata           - bus completion and read data
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,

    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int                      c_STREAK_W   = $clog2(FAIR_LIMIT + 1);
    localparam logic [c_STREAK_W-1:0]   c_STREAK_MAX = c_STREAK_W'(FAIR_LIMIT);
    localparam logic [c_STREAK_W-1:0]   c_STREAK_ONE = c_STREAK_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_STREAK_W-1:0]   r_streak;
    logic                    r_bus_req;
    logic                    r_bus_we;
    logic [1:0]              r_bus_size;
    logic [31:0]             r_bus_addr;
    logic [31:0]             r_bus_wdata;

    logic                    w_misaligned;
    logic                    w_if_wins;
    logic                    w_mem_grant;
    logic                    w_if_done;
    logic                    w_mem_done;
    logic                    w_err;
    logic [c_STREAK_W-1:0]   w_streak_inc;

    // Size 3 is reserved and is reported as misaligned.
    always_comb begin
        w_misaligned = 1'b0;
        case (mem_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = mem_addr[0];
            2'd2:    w_misaligned = (mem_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    // IF wins when MEM is absent, or when MEM has already taken its full
    // quota of consecutive grants while IF was waiting.
    assign w_if_wins    = if_req && (!mem_req || (r_streak == c_STREAK_MAX));
    assign w_mem_grant  = mem_req && !w_if_wins;
    assign w_streak_inc = (r_streak == c_STREAK_MAX) ? c_STREAK_MAX
                                                     : (r_streak + c_STREAK_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_size  <= 2'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_grant) begin
                        // Only grants that made a fetch wait extend the streak.
                        r_streak <= if_req ? w_streak_inc : '0;
                        if (w_misaligned) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_state     <= ST_BUSY_MEM;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_we;
                            r_bus_size  <= mem_size;
                            r_bus_addr  <= mem_addr;
                            r_bus_wdata <= mem_wdata;
                        end
                    end else if (if_req) begin
                        r_streak   <= '0;
                        r_state    <= ST_BUSY_IF;
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= 1'b0;
                        r_bus_size <= 2'd2;
                        r_bus_addr <= if_addr;
                    end
                end
                ST_BUSY_IF, ST_BUSY_MEM: begin
                    // Completes to IDLE even if the requester has dropped.
                    if (bus_ack) begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Completion strobes are combinational on bus_ack; reset masks them so
    // an abandoned transaction never reports completion.
    assign w_if_done  = !rst && (r_state == ST_BUSY_IF)  && bus_ack;
    assign w_mem_done = !rst && (r_state == ST_BUSY_MEM) && bus_ack;
    assign w_err      = !rst && (r_state == ST_ERR);

    assign if_ready  = w_if_done;
    assign if_rdata  = w_if_done ? bus_rdata : 32'd0;
    assign mem_ready = w_mem_done || w_err;
    assign mem_err   = w_err;
    assign mem_rdata = w_mem_done ? bus_rdata : 32'd0;

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_size  = r_bus_size;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Requester tasks push the
//                expected response when they issue a request; a monitor pops
//                and compares on every ready. A bus responder model returns
//                address-derived data with configurable wait states and
//                checks that bus transactions match a pending request and
//                stay stable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int FAIR_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_size  (bus_size),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    typedef struct {
        bit          err;
        logic [31:0] rdata;
    } mem_exp_t;

    logic [31:0] if_q[$];
    mem_exp_t    mem_q[$];
    byte         grant_log[$];

    int n_checks  = 0;
    int n_pass    = 0;
    int lat_fixed = -1;   // -1: random wait states 0..3
    int last_len  = 0;    // cycles bus_req was high for the last completed txn
    int n_txn     = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    endtask

    // Contents of the memory behind the bus.
    function automatic logic [31:0] rdf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic bit misaligned(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd3) return 1'b1;
        return (a % (32'd1 << size)) != 32'd0;
    endfunction

    // ------------------------------------------------------------------ bus
    initial begin : responder
        bit          active;
        int          wl;
        int          len;
        logic        s_we;
        logic [1:0]  s_size;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        bit          is_if;
        bit          is_mem;
        active    = 1'b0;
        wl        = 0;
        len       = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    len    = 0;
                    wl     = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
                    n_txn++;
                    s_we = bus_we; s_size = bus_size; s_addr = bus_addr; s_wdata = bus_wdata;
                    is_if  = if_req && !bus_we && (bus_size == 2'd2) && (bus_addr == if_addr);
                    is_mem = mem_req && !misaligned(mem_size, mem_addr) &&
                             (bus_we == mem_we) && (bus_size == mem_size) &&
                             (bus_addr == mem_addr) && (bus_wdata == mem_wdata);
                    chk(is_if || is_mem, "bus_txn_matches_request", bus_addr,
                        mem_req ? mem_addr : if_addr);
                end else begin
                    chk({s_we, s_size, s_addr, s_wdata} == {bus_we, bus_size, bus_addr, bus_wdata},
                        "bus_ctrl_stable", bus_addr, s_addr);
                end
                len++;
                if (wl == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdf(bus_addr);
                    last_len  = len;
                    active    = 1'b0;
                end else begin
                    wl--;
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
            end else begin
                // Idle bus: junk ack/data must be ignored by the DUT.
                active    = 1'b0;
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
    end

    // -------------------------------------------------------------- monitor
    initial begin : monitor
        int          mem_while_if;
        mem_exp_t    e;
        logic [31:0] x;
        mem_while_if = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1)
                chk(!(if_ready || mem_ready || mem_err), "no_ready_in_reset",
                    32'({if_ready, mem_ready, mem_err}), 32'd0);
            if (if_ready === 1'b1) begin
                grant_log.push_back("I");
                chk(mem_while_if <= FAIR_LIMIT + 1, "if_wait_bound",
                    mem_while_if, FAIR_LIMIT + 1);
                mem_while_if = 0;
                if (if_q.size() == 0) chk(1'b0, "if_ready_unexpected", 32'd1, 32'd0);
                else begin
                    x = if_q.pop_front();
                    chk(if_rdata === x, "if_rdata", if_rdata, x);
                end
            end else begin
                chk(if_rdata === 32'd0, "if_rdata_idle", if_rdata, 32'd0);
            end
            if (mem_ready === 1'b1) begin
                grant_log.push_back("M");
                if (if_req) mem_while_if++;
                if (mem_q.size() == 0) chk(1'b0, "mem_ready_unexpected", 32'd1, 32'd0);
                else begin
                    e = mem_q.pop_front();
                    chk(mem_err === e.err, "mem_err", 32'(mem_err), 32'(e.err));
                    if (!e.err) chk(mem_rdata === e.rdata, "mem_rdata", mem_rdata, e.rdata);
                end
                if (mem_err === 1'b1) chk(bus_req === 1'b0, "no_bus_on_err", 32'(bus_req), 32'd0);
            end else begin
                chk((mem_err === 1'b0) && (mem_rdata === 32'd0), "mem_idle_outputs",
                    mem_rdata ^ 32'(mem_err), 32'd0);
            end
            if (!if_req) mem_while_if = 0;
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic if_access(input logic [31:0] addr, output int cyc);
        if_addr = addr;
        if_req  = 1'b1;
        if_q.push_back(rdf(addr));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (if_ready !== 1'b1 && cyc < 300);
        if (if_ready !== 1'b1) chk(1'b0, "if_timeout", cyc, 300);
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        if_addr = $urandom;
    endtask

    task automatic mem_access(input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output int cyc);
        mem_exp_t e;
        e.err   = misaligned(size, addr);
        e.rdata = e.err ? 32'd0 : rdf(addr);
        mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        mem_req = 1'b1;
        mem_q.push_back(e);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (mem_ready !== 1'b1 && cyc < 300);
        if (mem_ready !== 1'b1) chk(1'b0, "mem_timeout", cyc, 300);
        @(posedge clk);
        #1;
        mem_req   = 1'b0;
        mem_we    = 1'($urandom_range(0, 1));
        mem_size  = 2'($urandom_range(0, 3));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main
    initial begin : main
        int    c;
        int    t0;
        string pat;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(bus_req   === 1'b0,  "rst_bus_req",   32'(bus_req),  32'd0);
        chk(bus_we    === 1'b0,  "rst_bus_we",    32'(bus_we),   32'd0);
        chk(bus_size  === 2'd0,  "rst_bus_size",  32'(bus_size), 32'd0);
        chk(bus_addr  === 32'd0, "rst_bus_addr",  bus_addr,      32'd0);
        chk(bus_wdata === 32'd0, "rst_bus_wdata", bus_wdata,     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fetch with ack three cycles after grant
        lat_fixed = 2;
        if_access(32'h100, c);
        chk(c == 4, "if_latency", c, 4);
        chk(last_len == 3, "if_bus_req_cycles", last_len, 3);

        // Store word with five bus cycles
        lat_fixed = 4;
        mem_access(1'b1, 2'd2, 32'h40, 32'h12345678, c);
        chk(c == 6, "store_latency", c, 6);
        chk(last_len == 5, "store_bus_req_cycles", last_len, 5);

        // Misaligned accesses: error on the following cycle, no bus activity
        lat_fixed = 0;
        t0 = n_txn;
        mem_access(1'b0, 2'd1, 32'h3, 32'd0, c);
        chk(c == 2, "misaligned_half_latency", c, 2);
        mem_access(1'b0, 2'd2, 32'h2, 32'd0, c);
        chk(c == 2, "misaligned_word_latency", c, 2);
        mem_access(1'b1, 2'd3, 32'h0, 32'hFFFF, c);
        chk(c == 2, "reserved_size_latency", c, 2);
        chk(n_txn == t0, "misaligned_no_bus", n_txn, t0);

        // Fairness with both ports held and immediate ack
        reset_pulse();
        grant_log.delete();
        fork
            begin
                repeat (2) if_access($urandom, c);
            end
            begin
                int cm;
                repeat (8) mem_access(1'b0, 2'd2, $urandom & 32'hFFFF_FFFC, 32'd0, cm);
            end
        join
        pat = "MMMMIMMMMI";
        chk(grant_log.size() == 10, "grant_pattern_len", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk(grant_log[i] == pat[i], "grant_pattern", 32'(grant_log[i]), 32'(pat[i]));

        // Reset in the cycle the bus acks a pending load
        lat_fixed = 2;
        mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h80; mem_wdata = 32'd0;
        mem_req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        mem_req = 1'b0;
        @(negedge clk);
        chk(mem_ready === 1'b0, "ready_masked_by_rst", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(bus_req === 1'b0, "bus_req_after_rst", 32'(bus_req), 32'd0);
        @(posedge clk);
        #1;
        lat_fixed = -1;
        mem_access(1'b0, 2'd2, 32'h84, 32'd0, c);
        if_access(32'h200, c);

        // Randomized traffic on both ports
        fork
            begin
                int g;
                int ci;
                repeat (40) begin
                    g = int'($urandom_range(0, 3));
                    repeat (g) @(posedge clk);
                    if (g > 0) #1;
                    if_access($urandom, ci);
                end
            end
            begin
                int g;
                int cm;
                logic [31:0] a;
                repeat (60) begin
                    g = int'($urandom_range(0, 2));
                    repeat (g) @(posedge clk);
                    if (g > 0) #1;
                    a = $urandom;
                    if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
                    mem_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, cm);
                end
            end
        join

        repeat (5) @(posedge clk);
        chk(if_q.size() == 0, "if_queue_drained", if_q.size(), 0);
        chk(mem_q.size() == 0, "mem_queue_drained", mem_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
